// File: rtl/can_reg_responder_pkg.sv
// Shared definitions for the CAN controller register responder:
// register map, bit positions and the bus FSM states.
package can_reg_pkg;

   localparam logic [7:0] A_CTRL     = 8'h00;
   localparam logic [7:0] A_STATUS   = 8'h04;
   localparam logic [7:0] A_INT_EN   = 8'h08;
   localparam logic [7:0] A_INT_STAT = 8'h0C;
   localparam logic [7:0] A_BTR      = 8'h10;
   localparam logic [7:0] A_TX_ID    = 8'h14;
   localparam logic [7:0] A_TX_LO    = 8'h18;
   localparam logic [7:0] A_TX_HI    = 8'h1C;
   localparam logic [7:0] A_RX_ID    = 8'h20;
   localparam logic [7:0] A_RX_LO    = 8'h24;
   localparam logic [7:0] A_RX_HI    = 8'h28;

   localparam int CTRL_TXREQ   = 0;
   localparam int CTRL_EN      = 1;
   localparam int CTRL_DLC_LSB = 4;

   localparam int ST_BUSY   = 0;
   localparam int ST_RXPEND = 1;
   localparam int ST_RXOVR  = 2;

   localparam int IRQ_TX   = 0;
   localparam int IRQ_RX   = 1;
   localparam int IRQ_BERR = 2;
   localparam int IRQ_N    = 3;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   function automatic logic is_ro(input logic [7:0] a);
      return a inside {A_STATUS, A_RX_ID, A_RX_LO, A_RX_HI};
   endfunction

endpackage

// File: rtl/can_reg_responder_if.sv
// IP2Can/Can2IP register bus between the user-interface bridge
// (master) and the CAN register responder (slave).
interface can_reg_responder_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 8
);

   logic              IP2Can_CS;
   logic              IP2Can_RW;
   logic [ADDR_W-1:0] IP2Can_addr;
   logic [DATA_W-1:0] IP2Can_data;
   logic [DATA_W-1:0] Can2IP_data;
   logic              Can2IP_ack;
   logic              Can2IP_error;
   logic              Can2IP_interrupt;

   modport master (
      output IP2Can_CS,
      output IP2Can_RW,
      output IP2Can_addr,
      output IP2Can_data,
      input  Can2IP_data,
      input  Can2IP_ack,
      input  Can2IP_error,
      input  Can2IP_interrupt
   );

   modport slave (
      input  IP2Can_CS,
      input  IP2Can_RW,
      input  IP2Can_addr,
      input  IP2Can_data,
      output Can2IP_data,
      output Can2IP_ack,
      output Can2IP_error,
      output Can2IP_interrupt
   );

endinterface

// File: rtl/can_reg_responder_irq_ctrl.sv
// Interrupt status (event set / write-1-to-clear), enable mask
// and the registered level interrupt.
module can_irq_ctrl
   import can_reg_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IRQ_N-1:0] ev,
   input  logic [IRQ_N-1:0] w1c,
   input  logic             en_we,
   input  logic [IRQ_N-1:0] en_d,
   output logic [IRQ_N-1:0] stat,
   output logic [IRQ_N-1:0] en,
   output logic             irq
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stat <= '0;
         en   <= '0;
         irq  <= 1'b0;
      end else begin
         // an event arriving with its own clear keeps the bit set
         stat <= (stat & ~w1c) | ev;
         if (en_we)
            en <= en_d;
         irq <= |(stat & en);
      end
   end

endmodule

// File: rtl/can_reg_responder.sv
// Slave end of the IP2Can register bus: access FSM, decode,
// register file and TX/RX hand-off to the CAN protocol core.
module can_reg_responder
   import can_reg_pkg::*;
#(
   parameter int          DATA_W  = 32,
   parameter int          ADDR_W  = 8,
   parameter logic [31:0] BTR_RST = 32'h0000_0000
) (
   input  logic               sys_clk,
   input  logic               IP2Can_reset_n,
   can_reg_responder_if.slave bus,
   output logic               can_enable,
   output logic [31:0]        can_btr,
   output logic               can_tx_start,
   output logic [28:0]        can_tx_id,
   output logic [3:0]         can_tx_dlc,
   output logic [63:0]        can_tx_data,
   input  logic               can_tx_done,
   input  logic               can_rx_valid,
   input  logic [28:0]        can_rx_id,
   input  logic [3:0]         can_rx_dlc,
   input  logic [63:0]        can_rx_data,
   input  logic               can_bus_err
);

   state_t state, state_nx;

   logic [ADDR_W-1:0] a_addr;
   logic              a_rw;
   logic [DATA_W-1:0] a_data;

   logic [DATA_W-1:0] rd_val;
   logic [DATA_W-1:0] rdata;
   logic              ack;
   logic              err;

   logic [3:0]  dlc;
   logic        en;
   logic [31:0] btr;
   logic [28:0] tx_id;
   logic [31:0] tx_lo;
   logic [31:0] tx_hi;
   logic        tx_start;
   logic        tx_busy;

   logic        rx_pend;
   logic        rx_ovr;
   logic [28:0] rx_id;
   logic [3:0]  rx_dlc;
   logic [31:0] rx_lo;
   logic [31:0] rx_hi;

   logic [IRQ_N-1:0] int_stat;
   logic [IRQ_N-1:0] int_en;
   logic [IRQ_N-1:0] irq_ev;
   logic [IRQ_N-1:0] irq_w1c;
   logic             irq;

   logic commit;
   logic mapped;
   logic tx_clash;
   logic acc_err;
   logic wr;
   logic rd;
   logic tx_go;
   logic rd_rxhi;
   logic rd_stat;
   logic rx_take;
   logic rx_drop;

   always_ff @(posedge sys_clk) begin
      if (!IP2Can_reset_n)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (bus.IP2Can_CS) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    if (!bus.IP2Can_CS) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!IP2Can_reset_n) begin
         a_addr <= '0;
         a_rw   <= 1'b0;
         a_data <= '0;
      end else if (state == IDLE && bus.IP2Can_CS) begin
         a_addr <= bus.IP2Can_addr;
         a_rw   <= bus.IP2Can_RW;
         a_data <= bus.IP2Can_data;
      end
   end

   // misaligned offsets never match an entry, so they land in default
   always_comb begin
      rd_val = '0;
      mapped = 1'b1;
      unique case (a_addr)
         A_CTRL:     rd_val = {24'b0, dlc, 2'b0, en, 1'b0};
         A_STATUS:   rd_val = {29'b0, rx_ovr, rx_pend, tx_busy};
         A_INT_EN:   rd_val = {29'b0, int_en};
         A_INT_STAT: rd_val = {29'b0, int_stat};
         A_BTR:      rd_val = btr;
         A_TX_ID:    rd_val = {3'b0, tx_id};
         A_TX_LO:    rd_val = tx_lo;
         A_TX_HI:    rd_val = tx_hi;
         A_RX_ID:    rd_val = {rx_dlc, 28'b0} | {3'b0, rx_id};
         A_RX_LO:    rd_val = rx_lo;
         A_RX_HI:    rd_val = rx_hi;
         default:    mapped = 1'b0;
      endcase
   end

   assign commit   = (state == ACCESS);
   assign tx_clash = (a_addr == A_CTRL) && !a_rw
                   && a_data[CTRL_TXREQ] && tx_busy;
   assign acc_err  = !mapped || (!a_rw && is_ro(a_addr)) || tx_clash;
   assign wr       = commit && !a_rw && !acc_err;
   assign rd       = commit && a_rw && !acc_err;
   assign tx_go    = wr && (a_addr == A_CTRL) && a_data[CTRL_TXREQ];
   assign rd_rxhi  = rd && (a_addr == A_RX_HI);
   assign rd_stat  = rd && (a_addr == A_STATUS);

   // a frame arriving while the old one is being drained replaces it
   assign rx_take  = can_rx_valid && (!rx_pend || rd_rxhi);
   assign rx_drop  = can_rx_valid && rx_pend && !rd_rxhi;

   always_ff @(posedge sys_clk) begin
      if (!IP2Can_reset_n) begin
         ack   <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end else if (commit) begin
         ack   <= 1'b1;
         err   <= acc_err;
         rdata <= rd ? rd_val : '0;
      end else if (state == RESP && !bus.IP2Can_CS) begin
         ack   <= 1'b0;
         err   <= 1'b0;
         rdata <= '0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!IP2Can_reset_n) begin
         dlc   <= '0;
         en    <= 1'b0;
         btr   <= BTR_RST;
         tx_id <= '0;
         tx_lo <= '0;
         tx_hi <= '0;
      end else begin
         if (wr && a_addr == A_CTRL) begin
            dlc <= a_data[CTRL_DLC_LSB +: 4];
            en  <= a_data[CTRL_EN];
         end
         if (wr && a_addr == A_BTR)
            btr <= a_data[31:0];
         if (wr && a_addr == A_TX_ID)
            tx_id <= a_data[28:0];
         if (wr && a_addr == A_TX_LO)
            tx_lo <= a_data[31:0];
         if (wr && a_addr == A_TX_HI)
            tx_hi <= a_data[31:0];
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!IP2Can_reset_n) begin
         tx_start <= 1'b0;
         tx_busy  <= 1'b0;
      end else begin
         tx_start <= tx_go;
         if (tx_go)
            tx_busy <= 1'b1;
         else if (can_tx_done)
            tx_busy <= 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (!IP2Can_reset_n) begin
         rx_pend <= 1'b0;
         rx_ovr  <= 1'b0;
         rx_id   <= '0;
         rx_dlc  <= '0;
         rx_lo   <= '0;
         rx_hi   <= '0;
      end else begin
         if (rx_take) begin
            rx_pend <= 1'b1;
            rx_id   <= can_rx_id;
            rx_dlc  <= can_rx_dlc;
            rx_lo   <= can_rx_data[31:0];
            rx_hi   <= can_rx_data[63:32];
         end else if (rd_rxhi) begin
            rx_pend <= 1'b0;
         end
         if (rx_drop)
            rx_ovr <= 1'b1;
         else if (rd_stat)
            rx_ovr <= 1'b0;
      end
   end

   assign irq_ev[IRQ_TX]   = can_tx_done;
   assign irq_ev[IRQ_RX]   = can_rx_valid;
   assign irq_ev[IRQ_BERR] = can_bus_err;
   assign irq_w1c = (wr && a_addr == A_INT_STAT)
                  ? a_data[IRQ_N-1:0] : '0;

   can_irq_ctrl u_irq (
      .clk   (sys_clk),
      .rst_n (IP2Can_reset_n),
      .ev    (irq_ev),
      .w1c   (irq_w1c),
      .en_we (wr && a_addr == A_INT_EN),
      .en_d  (a_data[IRQ_N-1:0]),
      .stat  (int_stat),
      .en    (int_en),
      .irq   (irq)
   );

   assign bus.Can2IP_data      = rdata;
   assign bus.Can2IP_ack       = ack;
   assign bus.Can2IP_error     = err;
   assign bus.Can2IP_interrupt = irq;

   assign can_enable   = en;
   assign can_btr      = btr;
   assign can_tx_start = tx_start;
   assign can_tx_id    = tx_id;
   assign can_tx_dlc   = dlc;
   assign can_tx_data  = {tx_hi, tx_lo};

endmodule
